led_pattern_sequencer: RTL and testbench

LED_PATTERN_SEQUENCER -- requirements
Module: led_pattern_sequencer

---
 rtl/led_pattern_sequencer.sv | 126 ++++++++++++
 tb/tb_led_pattern_sequencer.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/led_pattern_sequencer.sv
// LED pattern sequencer: steps a BLINK/CHASE/BOUNCE/COUNT pattern once per
// rising edge of a slow tick_src, with enable/pause control and a small FSM.
`timescale 1ns/1ps
module led_pattern_sequencer #(
    parameter int unsigned LED_COUNT   = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 clk_in,
    input  logic                 rst,
    input  logic                 tick_src,
    input  logic                 enable,
    input  logic                 pause,
    input  logic [1:0]           mode,
    output logic [LED_COUNT-1:0] led,
    output logic                 step_pulse,
    output logic [1:0]           state
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        HOLD = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        BLINK  = 2'b00,
        CHASE  = 2'b01,
        BOUNCE = 2'b10,
        COUNT  = 2'b11
    } mode_t;

    localparam logic [LED_COUNT-1:0] LED_ONE = {{(LED_COUNT-1){1'b0}}, 1'b1};

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   dly_q, dly_d;
    logic                   step_req;

    state_t                 state_q, state_d;
    mode_t                  mode_q, mode_d;
    logic [LED_COUNT-1:0]   led_q, led_d;
    logic                   dir_up_q, dir_up_d;
    logic                   step_pulse_q, step_pulse_d;

    function automatic logic [LED_COUNT-1:0] init_pattern(input mode_t m);
        logic [LED_COUNT-1:0] p;
        case (m)
            CHASE, BOUNCE: p = LED_ONE;
            default:       p = '0;
        endcase
        return p;
    endfunction

    // Synchronizer and edge detector run regardless of FSM state.
    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], tick_src};
        dly_d    = sync_q[SYNC_STAGES-1];
        step_req = sync_q[SYNC_STAGES-1] & ~dly_q;
    end

    always_comb begin
        mode_d       = mode_t'(mode);
        state_d      = state_q;
        led_d        = led_q;
        dir_up_d     = dir_up_q;
        step_pulse_d = 1'b0;

        if (!enable) begin
            state_d  = IDLE;
            led_d    = '0;
            dir_up_d = 1'b1;
        end else if (state_q == IDLE || mode_d != mode_q) begin
            // Entering from IDLE and a mode change both restart the pattern;
            // any step request in this cycle is dropped.
            led_d    = init_pattern(mode_d);
            dir_up_d = 1'b1;
            state_d  = pause ? HOLD : RUN;
        end else if (pause) begin
            state_d = HOLD;
        end else begin
            state_d = RUN;
            if (step_req) begin
                step_pulse_d = 1'b1;
                case (mode_q)
                    BLINK: led_d = ~led_q;
                    CHASE: led_d = {led_q[LED_COUNT-2:0], led_q[LED_COUNT-1]};
                    BOUNCE: begin
                        if (dir_up_q) begin
                            led_d = led_q << 1;
                            if (led_d[LED_COUNT-1]) dir_up_d = 1'b0;
                        end else begin
                            led_d = led_q >> 1;
                            if (led_d[0]) dir_up_d = 1'b1;
                        end
                    end
                    COUNT:   led_d = led_q + LED_ONE;
                    default: led_d = led_q;
                endcase
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            sync_q       <= '0;
            dly_q        <= 1'b0;
            state_q      <= IDLE;
            mode_q       <= BLINK;
            led_q        <= '0;
            dir_up_q     <= 1'b1;
            step_pulse_q <= 1'b0;
        end else begin
            sync_q       <= sync_d;
            dly_q        <= dly_d;
            state_q      <= state_d;
            mode_q       <= mode_d;
            led_q        <= led_d;
            dir_up_q     <= dir_up_d;
            step_pulse_q <= step_pulse_d;
        end
    end

    assign led        = led_q;
    assign step_pulse = step_pulse_q;
    assign state      = state_q;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Scoreboard bench for led_pattern_sequencer (LED_COUNT=4, SYNC_STAGES=2).
`timescale 1ns/1ps
module tb_led_pattern_sequencer;

    logic       clk_in = 1'b0;
    logic       rst;
    logic       tick_src;
    logic       enable;
    logic       pause;
    logic [1:0] mode;
    logic [3:0] led;
    logic       step_pulse;
    logic [1:0] state;

    logic [3:0]  exp_q[$];
    int unsigned errors = 0;
    int unsigned checks = 0;

    led_pattern_sequencer #(
        .LED_COUNT   (4),
        .SYNC_STAGES (2)
    ) dut (
        .clk_in     (clk_in),
        .rst        (rst),
        .tick_src   (tick_src),
        .enable     (enable),
        .pause      (pause),
        .mode       (mode),
        .led        (led),
        .step_pulse (step_pulse),
        .state      (state)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One tick_src period; step_pulse must appear exactly 2 edges after the
    // first edge that samples tick_src high, and nowhere else.
    task automatic tick(input bit exp_step);
        tick_src = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk_in); #1;
            check("pulse_lat", 32'(step_pulse), 32'(exp_step && i == 2));
        end
        @(negedge clk_in);
        tick_src = 1'b0;
        repeat (4) @(negedge clk_in);
    endtask

    task automatic edge_check(input string tag, input logic [3:0] exp_led, input logic [1:0] exp_state);
        @(posedge clk_in); #1;
        check({tag, "_led"}, 32'(led), 32'(exp_led));
        check({tag, "_state"}, 32'(state), 32'(exp_state));
        @(negedge clk_in);
    endtask

    always @(negedge clk_in) begin
        if (rst === 1'b0 && step_pulse === 1'b1) begin
            if (exp_q.size() == 0) check("unexp_pulse", 32'(step_pulse), 32'(0));
            else check("led_step", 32'(led), 32'(exp_q.pop_front()));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; tick_src = 1'b0; enable = 1'b0; pause = 1'b0; mode = 2'b00;
        #1 rst = 1'b1;
        #1;
        check("rst_led", 32'(led), 32'(0));
        check("rst_state", 32'(state), 32'(0));
        check("rst_pulse", 32'(step_pulse), 32'(0));
        repeat (2) @(negedge clk_in);
        rst = 1'b0;
        @(negedge clk_in);
        check("idle_led", 32'(led), 32'(0));

        // CHASE
        mode = 2'b01; enable = 1'b1;
        edge_check("chase_init", 4'b0001, 2'b01);
        exp_q.push_back(4'b0010); exp_q.push_back(4'b0100);
        exp_q.push_back(4'b1000); exp_q.push_back(4'b0001);
        repeat (4) tick(1);

        // BOUNCE
        mode = 2'b10;
        edge_check("bounce_init", 4'b0001, 2'b01);
        exp_q.push_back(4'b0010); exp_q.push_back(4'b0100); exp_q.push_back(4'b1000);
        exp_q.push_back(4'b0100); exp_q.push_back(4'b0010); exp_q.push_back(4'b0001);
        exp_q.push_back(4'b0010); exp_q.push_back(4'b0100);
        repeat (8) tick(1);

        // COUNT through 1110 -> 1111 -> 0000
        mode = 2'b11;
        edge_check("count_init", 4'b0000, 2'b01);
        for (int i = 1; i <= 16; i++) exp_q.push_back(4'(i));
        repeat (16) tick(1);

        // BLINK with pause
        mode = 2'b00;
        edge_check("blink_init", 4'b0000, 2'b01);
        exp_q.push_back(4'b1111);
        tick(1);
        pause = 1'b1;
        edge_check("hold_enter", 4'b1111, 2'b10);
        repeat (3) tick(0);
        check("hold_led", 32'(led), 32'(4'b1111));
        check("hold_state", 32'(state), 32'(2'b10));
        pause = 1'b0;
        edge_check("hold_exit", 4'b1111, 2'b01);
        exp_q.push_back(4'b0000);
        tick(1);

        // Mode change coincident with a step request
        mode = 2'b11;
        edge_check("count2_init", 4'b0000, 2'b01);
        exp_q.push_back(4'b0001); exp_q.push_back(4'b0010);
        repeat (2) tick(1);
        tick_src = 1'b1;
        @(posedge clk_in); @(negedge clk_in);
        @(posedge clk_in); @(negedge clk_in);
        mode = 2'b01;
        @(posedge clk_in); #1;
        check("modechg_led", 32'(led), 32'(4'b0001));
        check("modechg_pulse", 32'(step_pulse), 32'(0));
        @(posedge clk_in); #1;
        check("modechg_drop", 32'(step_pulse), 32'(0));
        @(negedge clk_in);
        tick_src = 1'b0;
        repeat (4) @(negedge clk_in);
        enable = 1'b0;
        edge_check("disable", 4'b0000, 2'b00);

        // Async reset mid-CHASE, with tick_src high across release
        enable = 1'b1;
        edge_check("rechase_init", 4'b0001, 2'b01);
        exp_q.push_back(4'b0010);
        tick(1);
        @(posedge clk_in); #2;
        rst = 1'b1;
        #1;
        check("arst_led", 32'(led), 32'(0));
        check("arst_state", 32'(state), 32'(0));
        check("arst_pulse", 32'(step_pulse), 32'(0));
        @(negedge clk_in);
        tick_src = 1'b1;
        @(negedge clk_in);
        exp_q.push_back(4'b0010);
        rst = 1'b0;
        @(posedge clk_in); #1;
        check("rel_led", 32'(led), 32'(4'b0001));
        check("rel_state", 32'(state), 32'(2'b01));
        check("rel_pulse0", 32'(step_pulse), 32'(0));
        @(posedge clk_in); #1;
        check("rel_pulse1", 32'(step_pulse), 32'(0));
        @(posedge clk_in); #1;
        check("rel_pulse2", 32'(step_pulse), 32'(1));
        @(negedge clk_in);
        tick_src = 1'b0;
        repeat (4) @(negedge clk_in);

        check("sb_drain", 32'(exp_q.size()), 32'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
